// File: rtl/dram_cache_pkg.sv
// -----------------------------------------------------------------------------
// dram_cache_pkg
// Shared definitions for the two-way set-associative DRAM line cache:
//   - geometry: ADDR_W (byte address), INDEX_W (set index), LINE_W (line bits),
//     TAG_W, SETS, BYTES (bytes per line)
//   - state_t : controller states
//   - cpu_req_t : latched CPU request {addr, wen, wdata}
//   - tag_of / index_of / word_of : byte-address field extraction
// Address layout: [3:0] line offset, [3:2] word, [INDEX_W+3:4] index, rest tag.
// -----------------------------------------------------------------------------
package dram_cache_pkg;

    localparam int ADDR_W  = 27;
    localparam int INDEX_W = 8;
    localparam int LINE_W  = 128;
    localparam int TAG_W   = ADDR_W - INDEX_W - 4;
    localparam int SETS    = 1 << INDEX_W;
    localparam int BYTES   = LINE_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        RF_REQ,
        RF_WAIT,
        RESPOND
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [31:0]       wdata;
    } cpu_req_t;

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:INDEX_W+4];
    endfunction

    function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
        return addr[INDEX_W+3:4];
    endfunction

    function automatic logic [1:0] word_of(input logic [ADDR_W-1:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/dram_cache_way_ram.sv
// -----------------------------------------------------------------------------
// dram_cache_way_ram
// Data array for one cache way: SETS x LINE_W, synchronous read, byte-enabled
// write. Written so synthesis maps it onto block RAM with byte enables.
// Ports:
//   clk       rising-edge clock
//   rd_en     capture mem[rd_index] into rd_line on the next edge
//   rd_index  set to read
//   rd_line   registered read data; holds its value while rd_en is low
//   wr_en     write enable
//   wr_index  set to write
//   wr_be     per-byte write enable (bit b covers wr_line[8b+7:8b])
//   wr_line   write data
// -----------------------------------------------------------------------------
module dram_cache_way_ram
    import dram_cache_pkg::*;
(
    input  logic               clk,
    input  logic               rd_en,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [BYTES-1:0]   wr_be,
    input  logic [LINE_W-1:0]  wr_line
);

    logic [LINE_W-1:0] mem [SETS];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_line <= mem[rd_index];
        end
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_index][b*8 +: 8] <= wr_line[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dram_cache_2way.sv
// -----------------------------------------------------------------------------
// dram_cache_2way
// Two-way set-associative, write-back, write-allocate cache in front of the
// CPU-side DRAM request FIFO. One CPU word access outstanding at a time;
// misses block until the refill line returns.
// Ports:
//   sys_clk, rstn              clock; asynchronous active-low reset
//   cpu_req_valid/ready        CPU request handshake (ready only in IDLE)
//   cpu_addr, cpu_wen, cpu_wdata  byte address (bits [1:0] ignored), store flag, data
//   cpu_rvalid, cpu_rdata      one-cycle completion; load data, 0 for stores
//   mem_req_valid/ready        line request to the FIFO
//   mem_req_wen, mem_req_addr, mem_req_wdata  writeback(1)/refill(0), line addr, line
//   mem_rsp_valid/ready, mem_rsp_data  refill return
//   stat_hits, stat_misses     lookup counters
// Build option: define DRAM_CACHE_STATS_EN to build the hit/miss counters;
// without it both stat outputs are tied to 0.
// -----------------------------------------------------------------------------
module dram_cache_2way
    import dram_cache_pkg::*;
(
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wen,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [LINE_W-1:0] mem_rsp_data,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
);

    function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line,
                                             input logic [1:0] sel);
        return line[sel*32 +: 32];
    endfunction

    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                     input logic [1:0] sel,
                                                     input logic [31:0] data);
        logic [LINE_W-1:0] res;
        res = line;
        res[sel*32 +: 32] = data;
        return res;
    endfunction

    state_t   state, state_nxt;
    cpu_req_t req_q;
    logic     victim_q;
    logic [31:0] rdata_q;

    // Valid/dirty/LRU must clear asynchronously, so they live in flops.
    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  dirty_q [2];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q   [2][SETS];

    logic [LINE_W-1:0] rd_line [2];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         req_word;
    logic               hit0, hit1, hit_any, hit_way;
    logic               victim_way, victim_dirty;
    logic               hit_store, refill_wr;
    logic [1:0]         way_we;
    logic [BYTES-1:0]   wr_be;
    logic [LINE_W-1:0]  wr_line;
    logic [LINE_W-1:0]  rf_line;
    logic               unused_addr_lsbs;

    assign idx      = index_of(req_q.addr);
    assign req_tag  = tag_of(req_q.addr);
    assign req_word = word_of(req_q.addr);
    assign unused_addr_lsbs = ^req_q.addr[1:0];

    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
    assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == req_tag);
    assign hit_any = hit0 || hit1;
    assign hit_way = hit1;

    // Fill an empty way first (way 0 before way 1); only evict when both are valid.
    assign victim_way   = !valid_q[0][idx] ? 1'b0 :
                          !valid_q[1][idx] ? 1'b1 : lru_q[idx];
    assign victim_dirty = valid_q[victim_way][idx] && dirty_q[victim_way][idx];

    // A store miss merges its word into the refill line so one write suffices.
    assign rf_line   = req_q.wen ? merge_word(mem_rsp_data, req_word, req_q.wdata)
                                 : mem_rsp_data;
    assign hit_store = (state == LOOKUP) && hit_any && req_q.wen;
    assign refill_wr = (state == RF_WAIT) && mem_rsp_valid;

    assign way_we[0] = (hit_store && !hit_way) || (refill_wr && !victim_q);
    assign way_we[1] = (hit_store &&  hit_way) || (refill_wr &&  victim_q);
    assign wr_be     = refill_wr ? {BYTES{1'b1}}
                                 : ({{(BYTES-4){1'b0}}, 4'hF} << {req_word, 2'b00});
    assign wr_line   = refill_wr ? rf_line : {(LINE_W/32){req_q.wdata}};

    // The array read is only launched on accept, so rd_line keeps the victim
    // line stable for the whole writeback handshake.
    for (genvar w = 0; w < 2; w++) begin : g_way
        dram_cache_way_ram u_ram (
            .clk      (sys_clk),
            .rd_en    (state == IDLE && cpu_req_valid),
            .rd_index (index_of(cpu_addr)),
            .rd_line  (rd_line[w]),
            .wr_en    (way_we[w]),
            .wr_index (idx),
            .wr_be    (wr_be),
            .wr_line  (wr_line)
        );
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOOKUP && hit_any) begin
                lru_q[idx] <= ~hit_way;
                if (req_q.wen) begin
                    dirty_q[hit_way][idx] <= 1'b1;
                end
            end
            if (refill_wr) begin
                valid_q[victim_q][idx] <= 1'b1;
                dirty_q[victim_q][idx] <= req_q.wen;
                lru_q[idx]             <= ~victim_q;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (state == IDLE && cpu_req_valid) begin
            req_q <= {cpu_addr, cpu_wen, cpu_wdata};
        end
        if (state == LOOKUP) begin
            victim_q <= victim_way;
            rdata_q  <= get_word(hit_way ? rd_line[1] : rd_line[0], req_word);
        end
        if (refill_wr) begin
            tag_q[victim_q][idx] <= req_tag;
            rdata_q              <= get_word(rf_line, req_word);
        end
    end

    always_comb begin
        state_nxt     = state;
        cpu_req_ready = 1'b0;
        cpu_rvalid    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_wen   = 1'b0;
        mem_req_addr  = {req_q.addr[ADDR_W-1:4], 4'b0000};
        mem_rsp_ready = 1'b0;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit_any)           state_nxt = RESPOND;
                else if (victim_dirty) state_nxt = WB_REQ;
                else                   state_nxt = RF_REQ;
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_wen   = 1'b1;
                mem_req_addr  = {tag_q[victim_q][idx], idx, 4'b0000};
                if (mem_req_ready) state_nxt = RF_REQ;
            end
            RF_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = RF_WAIT;
            end
            RF_WAIT: begin
                mem_rsp_ready = 1'b1;
                if (mem_rsp_valid) state_nxt = RESPOND;
            end
            RESPOND: begin
                cpu_rvalid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req_wdata = rd_line[victim_q];
    assign cpu_rdata     = (state == RESPOND && !req_q.wen) ? rdata_q : 32'd0;

`ifdef DRAM_CACHE_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state == LOOKUP) begin
            if (hit_any) hits_q   <= hits_q + 32'd1;
            else         misses_q <= misses_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = 32'd0;
    assign stat_misses = 32'd0;
`endif

    a_single_hit: assert property (@(posedge sys_clk) disable iff (!rstn)
        (state == LOOKUP) |-> !(hit0 && hit1));

    a_rsp_only_in_wait: assert property (@(posedge sys_clk) disable iff (!rstn)
        (state != RF_WAIT) |-> !mem_rsp_valid);

endmodule

// File: tb/tb_dram_cache_2way.sv
// -----------------------------------------------------------------------------
// tb_dram_cache_2way
// Directed bench for dram_cache_2way: a table of CPU accesses with the
// expected memory-side traffic, load data and latency, followed by
// writeback backpressure and reset-during-refill sequences.
// -----------------------------------------------------------------------------
module tb_dram_cache_2way;

    logic         sys_clk;
    logic         rstn;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic [26:0]  cpu_addr;
    logic         cpu_wen;
    logic [31:0]  cpu_wdata;
    logic         cpu_rvalid;
    logic [31:0]  cpu_rdata;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_wen;
    logic [26:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_rsp_valid;
    logic         mem_rsp_ready;
    logic [127:0] mem_rsp_data;
    logic [31:0]  stat_hits;
    logic [31:0]  stat_misses;

    dram_cache_2way dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_addr      (cpu_addr),
        .cpu_wen       (cpu_wen),
        .cpu_wdata     (cpu_wdata),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // kind: 0 = hit, 1 = clean miss (refill only), 2 = dirty miss (writeback + refill)
    typedef struct {
        logic [26:0]  addr;
        logic         wen;
        logic [31:0]  wdata;
        logic [127:0] rsp_line;
        int           kind;
        logic [26:0]  wb_addr;
        logic [127:0] wb_line;
        logic [26:0]  rf_addr;
        logic [31:0]  rdata;
    } vec_t;

    localparam logic [127:0] L0  = 128'h33330003_22220002_DEADBEEF_11110000;
    localparam logic [127:0] L0M = 128'h33330003_12345678_DEADBEEF_11110000;
    localparam logic [127:0] L1  = 128'h77770003_66660002_55550001_44440000;
    localparam logic [127:0] L2  = 128'hBBBB0003_AAAA0002_99990001_88880000;
    localparam logic [127:0] L3  = 128'hFFFF0003_EEEE0002_DDDD0001_CCCC0000;
    localparam logic [127:0] L3M = 128'hFFFF0003_EEEE0002_CAFEF00D_CCCC0000;
    localparam logic [127:0] L4  = 128'h04040003_04040002_04040001_04040000;
    localparam logic [127:0] L5  = 128'h05050003_05050002_05050001_05050000;

    int checks = 0;
    int errors = 0;

    int           mreq_n;
    logic [26:0]  mreq_addr [4];
    logic         mreq_wen  [4];
    logic [127:0] mreq_data [4];
    logic [31:0]  rdata_seen;

    vec_t vt [12];
    int   exp_hits   = 0;
    int   exp_misses = 0;

    function automatic vec_t mk(input logic [26:0] a, input logic w, input logic [31:0] d,
                                input logic [127:0] rsp, input int kind,
                                input logic [26:0] wba, input logic [127:0] wbl,
                                input logic [26:0] rfa, input logic [31:0] rd);
        vec_t v;
        v.addr = a; v.wen = w; v.wdata = d; v.rsp_line = rsp; v.kind = kind;
        v.wb_addr = wba; v.wb_line = wbl; v.rf_addr = rfa; v.rdata = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_cpu_req_ready"}, 128'(cpu_req_ready), 128'(1'b1));
        chk({nm, "_cpu_rvalid"},    128'(cpu_rvalid),    128'(1'b0));
        chk({nm, "_cpu_rdata"},     128'(cpu_rdata),     128'(32'd0));
        chk({nm, "_mem_req_valid"}, 128'(mem_req_valid), 128'(1'b0));
        chk({nm, "_mem_rsp_ready"}, 128'(mem_rsp_ready), 128'(1'b0));
        chk({nm, "_stat_hits"},     128'(stat_hits),     128'(32'd0));
        chk({nm, "_stat_misses"},   128'(stat_misses),   128'(32'd0));
    endtask

    // Present one request; returns at the first falling edge after the accept edge.
    task automatic issue(input logic [26:0] a, input logic w, input logic [31:0] d,
                         input string nm);
        @(negedge sys_clk);
        chk({nm, "_req_ready"}, 128'(cpu_req_ready), 128'(1'b1));
        cpu_req_valid = 1'b1;
        cpu_addr      = a;
        cpu_wen       = w;
        cpu_wdata     = d;
        @(negedge sys_clk);
        cpu_req_valid = 1'b0;
    endtask

    // Acts as the FIFO/DRAM from the current falling edge: records accepted
    // line requests, answers refills at once, stops on cpu_rvalid.
    task automatic monitor(input logic [127:0] line, output int waited, output bit done);
        waited = 0;
        done   = 1'b0;
        mreq_n = 0;
        while (!done && waited < 60) begin
            mem_rsp_valid = 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                if (mreq_n < 4) begin
                    mreq_addr[mreq_n] = mem_req_addr;
                    mreq_wen[mreq_n]  = mem_req_wen;
                    mreq_data[mreq_n] = mem_req_wdata;
                end
                mreq_n++;
            end
            if (mem_rsp_ready) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = line;
            end
            if (cpu_rvalid) begin
                done       = 1'b1;
                rdata_seen = cpu_rdata;
            end else begin
                @(negedge sys_clk);
                waited++;
            end
        end
        mem_rsp_valid = 1'b0;
    endtask

    task automatic access(input vec_t v, input string nm);
        int waited;
        bit done;
        int exp_lat;
        issue(v.addr, v.wen, v.wdata, nm);
        monitor(v.rsp_line, waited, done);
        chk({nm, "_completed"}, 128'(done), 128'(1'b1));
        if (done) begin
            exp_lat = (v.kind == 0) ? 2 : (v.kind == 1) ? 4 : 5;
            chk({nm, "_latency"}, 128'(1 + waited), 128'(exp_lat));
            chk({nm, "_rdata"},   128'(rdata_seen), 128'(v.rdata));
        end
        chk({nm, "_mem_req_count"}, 128'(mreq_n), 128'(v.kind));
        if (v.kind == 1 && mreq_n >= 1) begin
            chk({nm, "_rf_wen"},  128'(mreq_wen[0]),  128'(1'b0));
            chk({nm, "_rf_addr"}, 128'(mreq_addr[0]), 128'(v.rf_addr));
        end
        if (v.kind == 2 && mreq_n >= 2) begin
            chk({nm, "_wb_wen"},  128'(mreq_wen[0]),  128'(1'b1));
            chk({nm, "_wb_addr"}, 128'(mreq_addr[0]), 128'(v.wb_addr));
            chk({nm, "_wb_line"}, mreq_data[0],       v.wb_line);
            chk({nm, "_rf_wen"},  128'(mreq_wen[1]),  128'(1'b0));
            chk({nm, "_rf_addr"}, 128'(mreq_addr[1]), 128'(v.rf_addr));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0]  wb_addr0;
        logic [127:0] wb_line0;
        bit           stable;
        int           waited;
        bit           done;
        int           wb_acc;
        int           n;

        // Cold load, hits, store hit, way-1 fill, dirty conflict, store miss.
        vt[0]  = mk(27'h0000104, 1'b0, 32'h0,        L0, 1, 27'h0, 128'h0, 27'h0000100, 32'hDEADBEEF);
        vt[1]  = mk(27'h0000104, 1'b0, 32'h0,        L0, 0, 27'h0, 128'h0, 27'h0,       32'hDEADBEEF);
        vt[2]  = mk(27'h0000108, 1'b1, 32'h12345678, L0, 0, 27'h0, 128'h0, 27'h0,       32'h0);
        vt[3]  = mk(27'h0000108, 1'b0, 32'h0,        L0, 0, 27'h0, 128'h0, 27'h0,       32'h12345678);
        vt[4]  = mk(27'h0000100, 1'b0, 32'h0,        L0, 0, 27'h0, 128'h0, 27'h0,       32'h11110000);
        vt[5]  = mk(27'h000110C, 1'b0, 32'h0,        L1, 1, 27'h0, 128'h0, 27'h0001100, 32'h77770003);
        vt[6]  = mk(27'h0002100, 1'b0, 32'h0,        L2, 2, 27'h0000100, L0M, 27'h0002100, 32'h88880000);
        vt[7]  = mk(27'h0001104, 1'b0, 32'h0,        L1, 0, 27'h0, 128'h0, 27'h0,       32'h55550001);
        vt[8]  = mk(27'h0003104, 1'b1, 32'hCAFEF00D, L3, 1, 27'h0, 128'h0, 27'h0003100, 32'h0);
        vt[9]  = mk(27'h0003104, 1'b0, 32'h0,        L3, 0, 27'h0, 128'h0, 27'h0,       32'hCAFEF00D);
        vt[10] = mk(27'h0003108, 1'b0, 32'h0,        L3, 0, 27'h0, 128'h0, 27'h0,       32'hEEEE0002);
        vt[11] = mk(27'h0004104, 1'b0, 32'h0,        L4, 1, 27'h0, 128'h0, 27'h0004100, 32'h04040001);

        rstn          = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_addr      = '0;
        cpu_wen       = 1'b0;
        cpu_wdata     = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;

        repeat (3) @(negedge sys_clk);
        check_reset("por");
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            access(vt[i], $sformatf("vec%0d", i));
            if (vt[i].kind == 0) exp_hits++;
            else                 exp_misses++;
        end

        // Dirty miss with the FIFO full for a while: way 0 holds 0x3100 dirty.
        mem_req_ready = 1'b0;
        issue(27'h0005100, 1'b0, 32'h0, "bp");
        exp_misses++;
        @(negedge sys_clk);
        chk("bp_wb_valid", 128'(mem_req_valid), 128'(1'b1));
        chk("bp_wb_wen",   128'(mem_req_wen),   128'(1'b1));
        chk("bp_wb_addr",  128'(mem_req_addr),  128'(27'h0003100));
        chk("bp_wb_line",  mem_req_wdata,       L3M);
        wb_addr0 = mem_req_addr;
        wb_line0 = mem_req_wdata;
        stable   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (!(mem_req_valid && mem_req_wen && mem_req_addr == wb_addr0 &&
                  mem_req_wdata == wb_line0 && !cpu_req_ready)) stable = 1'b0;
        end
        chk("bp_held_stable", 128'(stable), 128'(1'b1));
        mem_req_ready = 1'b1;
        monitor(L5, waited, done);
        chk("bp_completed", 128'(done), 128'(1'b1));
        chk("bp_rdata", 128'(rdata_seen), 128'(32'h05050000));
        wb_acc = 0;
        for (int i = 0; i < mreq_n && i < 4; i++) if (mreq_wen[i]) wb_acc++;
        chk("bp_wb_accept_count", 128'(wb_acc), 128'(1));
        chk("bp_mem_req_count", 128'(mreq_n), 128'(2));
        if (mreq_n >= 2) begin
            chk("bp_order_first_wb", 128'(mreq_wen[0]),  128'(1'b1));
            chk("bp_rf_addr",        128'(mreq_addr[1]), 128'(27'h0005100));
        end

`ifdef DRAM_CACHE_STATS_EN
        chk("stat_hits",   128'(stat_hits),   128'(exp_hits));
        chk("stat_misses", 128'(stat_misses), 128'(exp_misses));
`else
        chk("stat_hits_off",   128'(stat_hits),   128'(32'd0));
        chk("stat_misses_off", 128'(stat_misses), 128'(32'd0));
`endif

        // Reset while waiting for a refill.
        issue(27'h0006100, 1'b0, 32'h0, "rst");
        n = 0;
        while (!mem_rsp_ready && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        chk("rst_reached_rf_wait", 128'(mem_rsp_ready), 128'(1'b1));
        rstn = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge sys_clk);
        @(negedge sys_clk);
        rstn = 1'b1;

        // 0x5100 was cached before the reset, so it must miss now.
        access(mk(27'h0005100, 1'b0, 32'h0, L5, 1, 27'h0, 128'h0, 27'h0005100, 32'h05050000),
               "post_rst");
`ifdef DRAM_CACHE_STATS_EN
        chk("post_rst_stat_hits",   128'(stat_hits),   128'(32'd0));
        chk("post_rst_stat_misses", 128'(stat_misses), 128'(32'd1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_cache_2way.md
Name: dram_cache_2way

Overview:
- Two-way set-associative, write-back, write-allocate cache that sits directly upstream of the CPU-side DRAM request FIFO.
- It turns 32-bit CPU word loads and stores into 128-bit line refill and writeback requests on that FIFO.
- It consumes the FIFO's read-data return.
- One outstanding CPU request at a time; blocking on a miss.

Parameters:
- ADDR_W, 27, byte address width (128 MiB DRAM).
- INDEX_W, 8, set index bits (256 sets).
- LINE_W, 128, line width in bits (16 bytes, 4 words).

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  block can accept a request.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wen  in  1  1 = store, 0 = load.
- cpu_wdata  in  32  store data.
- cpu_rvalid  out  1  one-cycle completion pulse for both loads and stores.
- cpu_rdata  out  32  load data; 0 on store completion.
- mem_req_valid  out  1  line request to the DRAM FIFO.
- mem_req_ready  in  1  FIFO not full.
- mem_req_wen  out  1  1 = writeback, 0 = refill read.
- mem_req_addr  out  ADDR_W  line-aligned address; bits [3:0] = 0.
- mem_req_wdata  out  LINE_W  writeback line.
- mem_rsp_valid  in  1  refill data present.
- mem_rsp_ready  out  1  block consumes refill data.
- mem_rsp_data  in  LINE_W  refill line.
- stat_hits  out  32  hit counter (see Optional Feature).
- stat_misses  out  32  miss counter (see Optional Feature).

Behaviour:
- Address split: offset [3:0], word select [3:2], index [INDEX_W+3:4], tag [ADDR_W-1:INDEX_W+4].
- Per-set state:
  - Per way: valid bit, dirty bit, tag.
  - Per set: one LRU bit (points at the way to evict).
  - Data: two LINE_W arrays with synchronous read, inferable as BRAM.
- Reset:
  - State = IDLE.
  - All valid, dirty and LRU bits cleared. Asynchronous clear is required, so valid, dirty and LRU live in flops.
  - Outputs: cpu_req_ready = 1, cpu_rvalid = 0, cpu_rdata = 0, mem_req_valid = 0, mem_rsp_ready = 0, stats = 0.
- FSM states: IDLE, LOOKUP, WB_REQ, RF_REQ, RF_WAIT, RESPOND.
- IDLE:
  - cpu_req_ready = 1.
  - On cpu_req_valid, latch address, wen and wdata; issue the array read; go to LOOKUP.
- LOOKUP:
  - Compare both ways. At most one way may hit; a double hit is an assertion failure.
  - On hit:
    - Load: select the word.
    - Store: merge wdata into the line, write the array, set dirty.
    - Set LRU to the other way; go to RESPOND.
  - On miss, victim = first invalid way (way 0 before way 1), else the LRU way.
  - Victim valid and dirty: go to WB_REQ. Otherwise go to RF_REQ.
- WB_REQ:
  - mem_req_valid = 1, mem_req_wen = 1.
  - Address = {victim tag, index, 4'b0}; data = victim line.
  - Hold all fields stable until mem_req_ready, then go to RF_REQ.
  - The FIFO write is posted; no writeback acknowledge is expected.
- RF_REQ:
  - mem_req_valid = 1, mem_req_wen = 0, address = line-aligned request address.
  - On mem_req_ready, go to RF_WAIT.
- RF_WAIT:
  - mem_rsp_ready = 1.
  - On mem_rsp_valid:
    - Write the line into the victim way; store data is merged in the same write.
    - Set valid and tag; set dirty = cpu_wen.
    - Set LRU to the other way; go to RESPOND.
- RESPOND:
  - cpu_rvalid = 1 for exactly one cycle.
  - cpu_rdata: the selected word for a load; 0 for a store.
  - Go to IDLE.
- cpu_req_ready is 0 in every state except IDLE.
- Latency, counted from the accept edge:
  - Hit: cpu_rvalid 2 cycles later.
  - Clean miss: 4 + FIFO/DRAM latency.
  - Dirty miss: one extra handshake.
- Ordering: a writeback is always handed to the FIFO before the refill of the same miss. The downstream FIFO is in-order, so read-after-writeback to the same address is safe.
- mem_rsp_valid outside RF_WAIT is ignored (not consumed) and flagged by an assertion.
- Reset mid-operation drops any in-flight request. A FIFO entry that was already handed over is not recalled. The system must reset the FIFO side together with this block.

Optional Feature:
- Macro: DRAM_CACHE_STATS_EN.
- Defined:
  - stat_hits increments on every LOOKUP hit; stat_misses increments on every LOOKUP miss.
  - 32-bit wrapping counters, cleared by rstn.
- Undefined: both outputs are constant 0 and no counter flops are synthesised.

Decomposition:
- Package dram_cache_pkg holds:
  - ADDR_W, INDEX_W, LINE_W, TAG_W.
  - The state enum typedef.
  - A request struct {addr, wen, wdata}.
  - Field-extract functions tag_of, index_of, word_of.
- Natural sub-module: dram_cache_way_ram, one way's synchronous-read data array with byte-merge write. It is instantiated twice.

Test Plan:
- Cold load 0x0000100 → RF_REQ at 0x0000100; return line with word1 = 0xDEADBEEF for load 0x0000104 → cpu_rdata 0xDEADBEEF. A second load of 0x0000104 hits, with cpu_rvalid 2 cycles after accept and no mem_req.
- Store 0x12345678 to 0x0000108 (hit) → later load returns 0x12345678; no mem_req issued.
- Conflict:
  - Fill both ways of index 0x10 (addresses 0x0000100 and 0x0001100).
  - Dirty way 0 with a store.
  - Access 0x0002100 → writeback to 0x0000100 carrying the stored data, then refill 0x0002100.
  - Way 1 is retained.
- Hold mem_req_ready low for 10 cycles during WB_REQ → mem_req fields stable throughout, exactly one writeback accepted, cpu_req_ready stays 0.
- Assert rstn low during RF_WAIT → all outputs return to reset values immediately. The next load of a previously cached address misses.
- With DRAM_CACHE_STATS_EN defined, run 3 hits and 2 misses → stat_hits = 3, stat_misses = 2. Undefined → both outputs read 0.
